// File: rtl/mouse_cursor_ctrl.sv
// mouse_cursor_ctrl
//   Turns PS/2 mouse packets into a bounded screen cursor plus button state.
//   Packet deltas are summed into saturating accumulators. The cursor position
//   changes only on a frame-refresh tick, so the overlay never sees it move
//   in the middle of a frame. Button levels and presses are updated as soon as
//   each packet arrives.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | nothing uncommitted; refr_tick is ignored
//   PEND  | movement or a recenter request is waiting for refr_tick
//   APPLY | one cycle: write the snapshot into x_pos/y_pos
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   xm, ym       signed 9-bit deltas (ym positive = up), valid with m_done_tick
//   btnm         buttons {middle, right, left}, valid with m_done_tick
//   m_done_tick  packet-valid strobe
//   refr_tick    frame-refresh strobe
//   x_pos, y_pos committed cursor position
//   btn_state    last received button levels
//   btn_press    one-cycle rising-edge pulses per button
//   upd_tick     one-cycle pulse when x_pos/y_pos are committed
//   pending      high while movement or a recenter is held uncommitted
module mouse_cursor_ctrl #(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] xm,
  input  logic [8:0] ym,
  input  logic [2:0] btnm,
  input  logic       m_done_tick,
  input  logic       refr_tick,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] btn_state,
  output logic [2:0] btn_press,
  output logic       upd_tick,
  output logic       pending
);

  localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
  localparam logic [9:0] X_INIT_V = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_V = 10'(Y_INIT);

  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

  state_t state, state_nxt;
  logic signed [11:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt;
  logic signed [11:0] snap_x, snap_y;
  logic snap_rc, recenter, recenter_nxt, owe;
  logic mid_press, take;
  logic signed [12:0] x_sum, y_sum;

  function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                 input logic [8:0] d);
    logic signed [12:0] s;
    s = {a[11], a} + {{4{d[8]}}, d};
    if (s > 13'sd2047)
      return 12'sh7ff;
    else if (s < -13'sd2048)
      return 12'sh800;
    else
      return s[11:0];
  endfunction

  function automatic logic [9:0] clamp(input logic signed [12:0] v,
                                       input logic signed [12:0] mx);
    if (v < 13'sd0)
      return 10'd0;
    else if (v > mx)
      return mx[9:0];
    else
      return v[9:0];
  endfunction

  assign mid_press = m_done_tick & btnm[2] & ~btn_state[2];
  assign take      = (state == PEND) & refr_tick;
  assign pending   = (state == PEND);

  // Screen y grows downward, so upward mouse motion subtracts.
  assign x_sum = {3'b000, x_pos} + {snap_x[11], snap_x};
  assign y_sum = {3'b000, y_pos} - {snap_y[11], snap_y};

  always_comb begin
    acc_x_nxt    = take ? 12'sd0 : acc_x;
    acc_y_nxt    = take ? 12'sd0 : acc_y;
    recenter_nxt = recenter & ~take;
    // A middle press throws away everything, including its own delta.
    if (mid_press) begin
      acc_x_nxt    = 12'sd0;
      acc_y_nxt    = 12'sd0;
      recenter_nxt = 1'b1;
    end else if (m_done_tick) begin
      acc_x_nxt = sat_add(acc_x_nxt, xm);
      acc_y_nxt = sat_add(acc_y_nxt, ym);
    end

    state_nxt = state;
    case (state)
      IDLE:  if (m_done_tick) state_nxt = PEND;
      PEND:  if (refr_tick) state_nxt = APPLY;
      APPLY: begin
        // owe covers a zero-delta packet that arrived with the snapshot.
        if (owe || acc_x != 12'sd0 || acc_y != 12'sd0 || recenter || m_done_tick)
          state_nxt = PEND;
        else
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc_x     <= '0;
      acc_y     <= '0;
      recenter  <= 1'b0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_rc   <= 1'b0;
      owe       <= 1'b0;
      x_pos     <= X_INIT_V;
      y_pos     <= Y_INIT_V;
      btn_state <= '0;
      btn_press <= '0;
      upd_tick  <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc_x    <= acc_x_nxt;
      acc_y    <= acc_y_nxt;
      recenter <= recenter_nxt;
      upd_tick <= (state == APPLY);

      if (take) begin
        snap_x  <= acc_x;
        snap_y  <= acc_y;
        snap_rc <= recenter;
        owe     <= m_done_tick;
      end

      if (state == APPLY) begin
        if (snap_rc) begin
          x_pos <= X_INIT_V;
          y_pos <= Y_INIT_V;
        end else begin
          x_pos <= clamp(x_sum, X_MAX_S);
          y_pos <= clamp(y_sum, Y_MAX_S);
        end
      end

      if (m_done_tick) begin
        btn_state <= btnm;
        btn_press <= btnm & ~btn_state;
      end else begin
        btn_press <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mouse_cursor_ctrl.sv
// Self-checking bench for mouse_cursor_ctrl: directed scenarios with literal
// expectations, then randomized packets/refresh ticks checked every cycle
// against an integer-arithmetic reference model.
module tb_mouse_cursor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] xm = '0, ym = '0;
  logic [2:0] btnm = '0;
  logic       m_done_tick = 1'b0, refr_tick = 1'b0;
  logic [9:0] x_pos, y_pos;
  logic [2:0] btn_state, btn_press;
  logic       upd_tick, pending;

  int n_cmp = 0;
  int n_bad = 0;

  mouse_cursor_ctrl dut (
    .clk(clk), .reset(reset), .xm(xm), .ym(ym), .btnm(btnm),
    .m_done_tick(m_done_tick), .refr_tick(refr_tick),
    .x_pos(x_pos), .y_pos(y_pos), .btn_state(btn_state), .btn_press(btn_press),
    .upd_tick(upd_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integers) ----------------
  int m_x, m_y, m_ax, m_ay, m_sx, m_sy;
  bit m_rc, m_src, m_owe, m_pend, m_apply, m_upd;
  bit [2:0] m_bs, m_bp;
  int dx, dy;
  bit mid, tk, np;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_x = 320; m_y = 240; m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0;
      m_rc = 0; m_src = 0; m_owe = 0; m_pend = 0; m_apply = 0; m_upd = 0;
      m_bs = 0; m_bp = 0;
    end else begin
      dx  = int'($signed(xm));
      dy  = int'($signed(ym));
      mid = m_done_tick && btnm[2] && !m_bs[2];
      tk  = m_pend && refr_tick;
      // Is uncommitted work held after this edge?
      if (tk) np = 0;
      else if (m_apply) np = m_owe || m_ax != 0 || m_ay != 0 || m_rc || m_done_tick;
      else np = m_pend || m_done_tick;

      m_upd = m_apply;
      if (m_apply) begin
        if (m_src) begin m_x = 320; m_y = 240; end
        else begin m_x = clampi(m_x + m_sx, 639); m_y = clampi(m_y - m_sy, 479); end
      end
      if (m_done_tick) begin m_bp = btnm & ~m_bs; m_bs = btnm; end
      else m_bp = 0;
      if (tk) begin
        m_sx = m_ax; m_sy = m_ay; m_src = m_rc; m_owe = m_done_tick;
        m_ax = 0; m_ay = 0; m_rc = 0;
      end
      if (mid) begin m_ax = 0; m_ay = 0; m_rc = 1; end
      else if (m_done_tick) begin
        m_ax = m_ax + dx; if (m_ax > 2047) m_ax = 2047; if (m_ax < -2048) m_ax = -2048;
        m_ay = m_ay + dy; if (m_ay > 2047) m_ay = 2047; if (m_ay < -2048) m_ay = -2048;
      end
      m_apply = tk;
      m_pend  = np;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("x_pos", int'(x_pos), m_x);
    chk("y_pos", int'(y_pos), m_y);
    chk("btn_state", int'(btn_state), int'(m_bs));
    chk("btn_press", int'(btn_press), int'(m_bp));
    chk("upd_tick", int'(upd_tick), int'(m_upd));
    chk("pending", int'(pending), int'(m_pend));
  endtask

  // Drive one cycle of inputs, check at the following falling edge.
  task automatic cyc(input bit pkt, input int ddx, input int ddy,
                     input logic [2:0] b, input bit refr);
    m_done_tick = pkt;
    xm          = 9'(ddx);
    ym          = 9'(ddy);
    btnm        = b;
    refr_tick   = refr;
    @(negedge clk);
    m_done_tick = 1'b0;
    refr_tick   = 1'b0;
    cmp_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 3'b000, 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    cmp_model();
    chk("rst_x", int'(x_pos), 320);
    chk("rst_y", int'(y_pos), 240);
    chk("rst_upd", int'(upd_tick), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_btn", int'(btn_state), 0);
    #2 reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    pulse_reset();

    // refresh with nothing pending does nothing
    cyc(0, 0, 0, 3'b000, 1);
    idle(2);
    chk("idle_refr_upd", int'(upd_tick), 0);
    chk("idle_refr_x", int'(x_pos), 320);

    // +5/+3 then refresh
    cyc(1, 5, 3, 3'b000, 0);
    chk("pend_after_pkt", int'(pending), 1);
    cyc(0, 0, 0, 3'b000, 1);
    chk("no_early_upd", int'(upd_tick), 0);
    idle(1);
    chk("t2_x", int'(x_pos), 325);
    chk("t2_y", int'(y_pos), 237);
    chk("t2_upd", int'(upd_tick), 1);
    idle(1);
    chk("t2_upd_off", int'(upd_tick), 0);
    chk("t2_pend_off", int'(pending), 0);

    // three -255 packets clamp both axes
    for (int i = 0; i < 3; i++) cyc(1, -255, -255, 3'b000, 0);
    cyc(0, 0, 0, 3'b000, 1);
    idle(1);
    chk("t3_x", int'(x_pos), 0);
    chk("t3_y", int'(y_pos), 479);

    // ten +255 packets saturate the accumulator
    for (int i = 0; i < 10; i++) cyc(1, 255, 0, 3'b000, 0);
    cyc(0, 0, 0, 3'b000, 1);
    idle(1);
    chk("t4_x", int'(x_pos), 639);

    // refresh coincident with a packet owes a second commit
    pulse_reset();
    cyc(1, 4, 0, 3'b000, 0);
    cyc(1, 10, 0, 3'b000, 1);
    idle(1);
    chk("t5_x1", int'(x_pos), 324);
    chk("t5_upd1", int'(upd_tick), 1);
    chk("t5_repend", int'(pending), 1);
    cyc(0, 0, 0, 3'b000, 1);
    idle(1);
    chk("t5_x2", int'(x_pos), 334);

    // button presses and middle-button recenter
    cyc(1, 0, 0, 3'b001, 0);
    chk("t6_press_l", int'(btn_press), 1);
    cyc(1, 0, 0, 3'b101, 0);
    chk("t6_press_m", int'(btn_press), 4);
    chk("t6_state", int'(btn_state), 5);
    idle(1);
    chk("t6_press_off", int'(btn_press), 0);
    cyc(0, 0, 0, 3'b000, 1);
    idle(1);
    chk("t6_rc_x", int'(x_pos), 320);
    chk("t6_rc_y", int'(y_pos), 240);

    // reset while pending
    cyc(1, 7, 7, 3'b000, 0);
    pulse_reset();
    idle(3);
    chk("t7_no_upd", int'(upd_tick), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit p, r;
      p = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 5) == 0);
      cyc(p, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
          3'($urandom_range(0, 7)), r);
      if (i % 1500 == 1499) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
